// File: rtl/spi_slave_if.sv
// SPI peripheral bus bundle: serial pins from the link plus the parallel tx/rx word side.
// Pure wiring, no storage and no added latency.
// tx_load is a strobe gated by tx_ready; rx_valid is a one-cycle pulse with no backpressure.
`timescale 1ns/1ps
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             sck;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  // External master / test side
  modport master (
    output sck, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );

  // Peripheral endpoint side
  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 peripheral: oversamples sck/cs_n/mosi in clk50M, MSB-first shift in/out.
// Latency: pin edge to internal strobe 3 cycles; rx_valid one cycle after the final sck rise strobe.
// No backpressure: rx words overwrite rx_data; tx_load is ignored while tx_ready=0.
`timescale 1ns/1ps
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic       clk50M,
  input  logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic             r_sck_m, r_sck_s, r_sck_d;
  logic             r_cs_m, r_cs_s;
  logic             r_mosi_m, r_mosi_s;
  logic             r_armed;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift_rx;
  logic [WIDTH-1:0] r_shift_tx;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_ready;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_miso;
  logic             r_busy;

  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_start;
  logic             w_boundary;
  logic             w_word_load;
  logic             w_tx_accept;
  logic [WIDTH-1:0] w_next_word;

  assign w_sck_rise  = r_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s & r_sck_d;
  // A transfer only starts after chip select has been seen high at least once since reset,
  // so a cs_n held low through reset does not start a transfer on release.
  assign w_start     = (r_state == IDLE) & r_armed & ~r_cs_s;
  assign w_boundary  = (r_state == SHIFT) & ~r_cs_s & w_sck_fall & (r_bit_cnt == '0);
  assign w_word_load = w_start | w_boundary;
  assign w_tx_accept = bus.tx_load & r_tx_ready;
  assign w_next_word = r_tx_ready ? '0 : r_tx_buf;

  assign bus.miso     = r_miso;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;

  // Two-flop synchronisers plus one sck delay flop for edge strobes.
  // The cs synchroniser resets low so only a genuine high level can arm the start logic.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_m  <= 1'b0;
      r_sck_s  <= 1'b0;
      r_sck_d  <= 1'b0;
      r_cs_m   <= 1'b0;
      r_cs_s   <= 1'b0;
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sck_m  <= bus.sck;
      r_sck_s  <= r_sck_m;
      r_sck_d  <= r_sck_s;
      r_cs_m   <= bus.cs_n;
      r_cs_s   <= r_cs_m;
      r_mosi_m <= bus.mosi;
      r_mosi_s <= r_mosi_m;
      r_armed  <= r_armed | r_cs_s;
    end
  end

  // Single-entry transmit buffer; a same-cycle load and accept sends zeros and keeps the new data.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
    end else if (w_tx_accept) begin
      r_tx_buf   <= bus.tx_data;
      r_tx_ready <= 1'b0;
    end else if (w_word_load) begin
      r_tx_ready <= 1'b1;
    end
  end

  // Transfer FSM: shift in on sck rise, shift out on sck fall, abort on chip select release.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift_rx <= '0;
      r_shift_tx <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          r_busy <= 1'b0;
          if (w_start) begin
            r_state    <= SHIFT;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift_tx <= w_next_word;
            r_miso     <= w_next_word[WIDTH-1];
          end
        end
        SHIFT: begin
          if (r_cs_s) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_miso     <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift_rx <= '0;
            r_shift_tx <= '0;
          end else if (w_sck_rise) begin
            r_shift_rx <= {r_shift_rx[WIDTH-2:0], r_mosi_s};
            if (r_bit_cnt == LAST) begin
              r_rx_data  <= {r_shift_rx[WIDTH-2:0], r_mosi_s};
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_sck_fall) begin
            if (r_bit_cnt == '0) begin
              r_shift_tx <= w_next_word;
              r_miso     <= w_next_word[WIDTH-1];
            end else begin
              r_shift_tx <= {r_shift_tx[WIDTH-2:0], 1'b0};
              r_miso     <= r_shift_tx[WIDTH-2];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master at sck = clk50M/10.
// Expected words are hand-computed constants; rx_valid pulses are counted by a monitor.
// All checks go through one task that counts comparisons and mismatches.
`timescale 1ns/1ps
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   rx_cnt = 0;
  int   exp_rx = 0;
  logic [7:0] mi;
  logic [7:0] mi2;
  logic       b;

  spi_slave_if #(.WIDTH(8)) sif ();

  spi_slave #(.WIDTH(8)) dut (
    .clk50M (clk),
    .rst_n  (rst_n),
    .bus    (sif)
  );

  always #10 clk = ~clk;

  // Count rx_valid pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (sif.rx_valid === 1'b1) rx_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] v);
    sif.tx_data = v;
    sif.tx_load = 1'b1;
    @(negedge clk);
    sif.tx_load = 1'b0;
  endtask

  // One mode-0 bit: drive mosi in the low half, sample miso just before raising sck.
  // Optionally pulse tx_load during the high half.
  task automatic spi_bit(input logic bo, input bit do_load, input logic [7:0] ld, output logic bi);
    sif.mosi = bo;
    idle(5);
    bi = sif.miso;
    sif.sck = 1'b1;
    if (do_load) begin
      idle(4);
      tx_push(ld);
    end else begin
      idle(5);
    end
    sif.sck = 1'b0;
  endtask

  task automatic spi_word(input logic [7:0] mo, input int load_bit, input logic [7:0] ld,
                          output logic [7:0] mw);
    logic bit_in;
    mw = '0;
    for (int i = 0; i < 8; i++) begin
      spi_bit(mo[7-i], (i == load_bit), ld, bit_in);
      mw = {mw[6:0], bit_in};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    sif.sck     = 1'b0;
    sif.cs_n    = 1'b1;
    sif.mosi    = 1'b0;
    sif.tx_data = '0;
    sif.tx_load = 1'b0;
    idle(3);
    check("rst_miso",     16'(sif.miso),     16'h0);
    check("rst_rx_data",  16'(sif.rx_data),  16'h0);
    check("rst_rx_valid", 16'(sif.rx_valid), 16'h0);
    check("rst_busy",     16'(sif.busy),     16'h0);
    check("rst_tx_ready", 16'(sif.tx_ready), 16'h1);
    rst_n = 1'b1;
    idle(5);

    // Word receive with empty tx buffer
    sif.cs_n = 1'b0;
    spi_word(8'hA5, -1, 8'h00, mi);
    exp_rx++;
    idle(6);
    check("t1_busy",    16'(sif.busy),    16'h1);
    check("t1_rx_cnt",  16'(rx_cnt),      16'(exp_rx));
    check("t1_rx_data", 16'(sif.rx_data), 16'h00A5);
    check("t1_miso",    16'(mi),          16'h0000);
    sif.cs_n = 1'b1;
    idle(6);
    check("t1_busy_end", 16'(sif.busy), 16'h0);

    // Full duplex
    tx_push(8'h3C);
    check("t2_ready_lo", 16'(sif.tx_ready), 16'h0);
    sif.cs_n = 1'b0;
    idle(4);
    check("t2_ready_hi", 16'(sif.tx_ready), 16'h1);
    spi_word(8'h5A, -1, 8'h00, mi);
    exp_rx++;
    idle(6);
    check("t2_miso",    16'(mi),          16'h003C);
    check("t2_rx_data", 16'(sif.rx_data), 16'h005A);
    check("t2_rx_cnt",  16'(rx_cnt),      16'(exp_rx));
    sif.cs_n = 1'b1;
    idle(6);

    // Back-to-back words; second tx word loaded after the first word's final rise
    tx_push(8'h81);
    sif.cs_n = 1'b0;
    idle(4);
    spi_word(8'h11, 7, 8'h7E, mi);
    exp_rx++;
    check("t3_rx_first", 16'(sif.rx_data), 16'h0011);
    spi_word(8'h22, -1, 8'h00, mi2);
    exp_rx++;
    idle(6);
    check("t3_rx_second", 16'(sif.rx_data), 16'h0022);
    check("t3_rx_cnt",    16'(rx_cnt),      16'(exp_rx));
    check("t3_miso_w0",   16'(mi),          16'h0081);
    check("t3_miso_w1",   16'(mi2),         16'h007E);
    sif.cs_n = 1'b1;
    idle(6);

    // Abort after 5 bits, then a full word
    sif.cs_n = 1'b0;
    idle(4);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, 8'h00, b);
    sif.cs_n = 1'b1;
    idle(8);
    check("t4_rx_cnt",  16'(rx_cnt),      16'(exp_rx));
    check("t4_rx_hold", 16'(sif.rx_data), 16'h0022);
    check("t4_busy",    16'(sif.busy),    16'h0);
    sif.cs_n = 1'b0;
    idle(4);
    spi_word(8'h0F, -1, 8'h00, mi);
    exp_rx++;
    idle(6);
    check("t4_rx_data", 16'(sif.rx_data), 16'h000F);
    check("t4_rx_cnt2", 16'(rx_cnt),      16'(exp_rx));
    check("t4_miso",    16'(mi),          16'h0000);
    sif.cs_n = 1'b1;
    idle(6);

    // Second tx_load while buffer full is ignored
    tx_push(8'h11);
    tx_push(8'h22);
    check("t5_ready", 16'(sif.tx_ready), 16'h0);
    sif.cs_n = 1'b0;
    idle(4);
    spi_word(8'h33, -1, 8'h00, mi);
    exp_rx++;
    idle(6);
    check("t5_miso",    16'(mi),          16'h0011);
    check("t5_rx_data", 16'(sif.rx_data), 16'h0033);
    sif.cs_n = 1'b1;
    idle(6);

    // Reset mid-word, with cs_n held low across release
    tx_push(8'h99);
    sif.cs_n = 1'b0;
    idle(4);
    spi_bit(1'b1, 1'b0, 8'h00, b);
    spi_bit(1'b0, 1'b0, 8'h00, b);
    spi_bit(1'b1, 1'b0, 8'h00, b);
    idle(4);
    check("t6_pre_miso", 16'(sif.miso), 16'h1);
    check("t6_pre_busy", 16'(sif.busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso",     16'(sif.miso),     16'h0);
    check("t6_rst_busy",     16'(sif.busy),     16'h0);
    check("t6_rst_rx_data",  16'(sif.rx_data),  16'h0);
    check("t6_rst_tx_ready", 16'(sif.tx_ready), 16'h1);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    spi_word(8'hFF, -1, 8'h00, mi);
    idle(6);
    check("t6_no_rx",   16'(rx_cnt),      16'(exp_rx));
    check("t6_idle",    16'(sif.busy),    16'h0);
    check("t6_rx_zero", 16'(sif.rx_data), 16'h0);
    sif.cs_n = 1'b1;
    idle(6);
    sif.cs_n = 1'b0;
    idle(4);
    spi_word(8'h6B, -1, 8'h00, mi);
    exp_rx++;
    idle(6);
    check("t6_rx_data", 16'(sif.rx_data), 16'h006B);
    check("t6_rx_cnt",  16'(rx_cnt),      16'(exp_rx));
    sif.cs_n = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 peripheral endpoint: the responder at the far end of the link driven by spi_clk/sck.
- Oversamples sck, cs_n and mosi in the clk50M domain.
- Deserialises MSB-first words into rx_data and serialises tx_data onto miso.
- Used by the Pong top level to exchange paddle/score words with an external SPI master and for loopback testing of the master-side logic.

Parameters:
- WIDTH, 8, bits per SPI word (legal 2..16).

Ports:
- clk50M  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from master; asynchronous, CPOL=0.
- cs_n  input  1  chip select from master, active low; asynchronous.
- mosi  input  1  serial data from master; asynchronous.
- miso  output  1  serial data to master; 0 when deselected.
- tx_data  input  WIDTH  word to transmit next.
- tx_load  input  1  write strobe for tx_data; honoured only while tx_ready=1.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  WIDTH  last completely received word; held until next completion.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  transfer in progress (synchronised cs_n low).

Behaviour:
- Reset values:
  - miso=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1.
  - Shift registers=0, bit_cnt=0, tx_buf empty, state=IDLE.
- Synchronisation:
  - sck, cs_n and mosi each pass through 2 flops (sck_s, cs_s, mosi_s).
  - sck_s is delayed one more flop to give sck_rise and sck_fall single-cycle strobes.
  - Latency from pin edge to strobe: 3 clk50M cycles.
  - Supported sck: high and low phases each >= 4 clk50M cycles (sck <= 6.25 MHz). Faster sck is unsupported.
- Transmit buffer:
  - tx_load with tx_ready=1 stores tx_data in tx_buf and clears tx_ready next cycle.
  - tx_load with tx_ready=0 is ignored; the buffer is unchanged.
  - tx_buf is consumed (tx_ready->1) at every word load.
  - Word load with buffer empty loads all-zeros into shift_tx.
  - If tx_load and a word load land on the same cycle while the buffer is empty: zeros are sent, and tx_data is kept for the following word.
- FSM states: IDLE, SHIFT.
- IDLE:
  - busy=0, miso=0.
  - Transition to SHIFT on the cycle cs_s is first seen low.
  - On that transition: word load into shift_tx, bit_cnt=0, miso=shift_tx MSB.
- SHIFT:
  - busy=1.
  - On sck_rise: shift_rx <= {shift_rx[WIDTH-2:0], mosi_s}, bit_cnt++.
  - On sck_rise with bit_cnt==WIDTH-1:
    - rx_data <= completed word and rx_valid=1 on the next cycle (exactly one cycle).
    - bit_cnt wraps to 0.
  - On sck_fall with bit_cnt!=0: shift_tx left by 1; miso = new MSB.
  - On sck_fall with bit_cnt==0 (word boundary): word load for back-to-back transfer; miso = new MSB.
  - cs_s high returns to IDLE immediately, even mid-word. All three of the following apply:
    - Partial receive bits are discarded and no rx_valid is produced.
    - bit_cnt is cleared.
    - The partially sent tx word is lost; it is not re-queued.
- sck edges while in IDLE are ignored.
- mosi is sampled only on sck_rise.
- rx_data never changes except on word completion or reset.
- rst_n assertion at any time, including mid-word, forces all reset values asynchronously. The first transfer after reset requires a fresh cs_n falling edge.

Test Plan:
- Word receive: tx buffer empty; cs_n low, master sends 0xA5 at sck = clk50M/10 -> exactly one rx_valid pulse, rx_data=0xA5, miso bits all 0, busy=1 until cs_n high.
- Full duplex: tx_load 0x3C before cs_n fall; master sends 0x5A -> master samples 0x3C on miso, rx_data=0x5A, tx_ready returns to 1 at cs_n sync.
- Back-to-back: load 0x81, cs_n low; after the first word's final rise, tx_load 0x7E; master clocks 16 bits mosi=0x11,0x22 -> rx_valid pulses twice (0x11 then 0x22), miso stream 0x81 then 0x7E.
- Abort: cs_n high after 5 sck rises of 0xFF -> no rx_valid, rx_data keeps previous value, next full transfer of 0x0F yields rx_data=0x0F.
- tx_load ignored: tx_load 0x11 then tx_load 0x22 while tx_ready=0 -> transmitted word is 0x11.
- Reset mid-word: rst_n low after 3 bits -> outputs at reset values immediately; after release, with cs_n still low, no rx_valid until cs_n toggles high and low again.
